// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the datapath (master) and the data-memory
// responder (slave).
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  data_mem_re_in;
  logic                  data_mem_we_in;
  logic [1:0]            data_mem_size_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [31:0]           wdata_in;
  logic [31:0]           rdata_out;
  logic                  stall_out;
  logic                  ready_out;
  logic                  error_out;

  modport master (
    output data_mem_re_in, data_mem_we_in, data_mem_size_in, addr_in, wdata_in,
    input  rdata_out, stall_out, ready_out, error_out
  );

  modport slave (
    input  data_mem_re_in, data_mem_we_in, data_mem_size_in, addr_in, wdata_in,
    output rdata_out, stall_out, ready_out, error_out
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: byte/half/word loads and stores on a word RAM with a
// fixed wait latency, stalling the datapath while an access is in flight.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input logic             clk_in,
  input logic             rst_n_in,
  data_mem_ctrl_if.slave  bus
);

  localparam int         DEPTH    = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem [DEPTH];

  logic                  req;
  logic                  illegal;
  logic                  commit;
  logic [1:0]            lane;
  logic [31:0]           word_q;
  logic [31:0]           load_val;
  logic [31:0]           wshift;
  logic [3:0]            be;

  assign req    = bus.data_mem_re_in | bus.data_mem_we_in;
  assign commit = (state == WAIT) && (cnt == LAST_CNT);
  assign lane   = addr_q[1:0];
  assign word_q = mem[addr_q[ADDR_WIDTH-1:2]];
  assign wshift = wdata_q << {lane, 3'b000};

  // Legality is judged once, at acceptance, from the live request.
  always_comb begin
    illegal = (bus.data_mem_re_in & bus.data_mem_we_in) ||
              (bus.data_mem_size_in == 2'b11) ||
              (bus.data_mem_size_in == 2'b01 && bus.addr_in[0]) ||
              (bus.data_mem_size_in == 2'b10 && bus.addr_in[1:0] != 2'b00);
  end

  always_comb begin
    load_val = word_q;
    be       = 4'b1111;
    case (size_q)
      2'b00: begin
        load_val = {{24{word_q[{lane, 3'b000} + 7]}}, word_q[{lane, 3'b000} +: 8]};
        be       = 4'b0001 << lane;
      end
      2'b01: begin
        load_val = {{16{word_q[{lane[1], 4'b0000} + 15]}}, word_q[{lane[1], 4'b0000} +: 16]};
        be       = 4'b0011 << {lane[1], 1'b0};
      end
      default: begin
        load_val = word_q;
        be       = 4'b1111;
      end
    endcase
  end

  // RAM is not reset; a store lands only on its commit edge and never under reset.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && commit && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= bus.addr_in;
            size_q  <= bus.data_mem_size_in;
            wdata_q <= bus.wdata_in;
            we_q    <= bus.data_mem_we_in;
            err_q   <= illegal;
            cnt     <= 4'd0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (commit) begin
            rdata_q <= (we_q || err_q) ? 32'd0 : load_val;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata_out = rdata_q;
  assign bus.ready_out = (state == DONE);
  assign bus.error_out = (state == DONE) && err_q;
  assign bus.stall_out = ((state == IDLE) && req) || (state == WAIT);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a LATENCY=2 instance driven by a vector
// table, corner sequences and random traffic, plus a LATENCY=1 instance.
module tb_data_mem_ctrl;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  int   cyc      = 0;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  data_mem_ctrl_if #(.ADDR_WIDTH(10)) bus2 ();
  data_mem_ctrl_if #(.ADDR_WIDTH(10)) bus1 ();

  data_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(2)) dut2 (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus2)
  );

  data_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus1)
  );

  typedef struct {
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];

  // Byte-addressed reference memory per instance: sel 0 is LATENCY=2, sel 1 is LATENCY=1.
  logic [7:0] model_mem [2][1024];

  function automatic int lat_of(input int sel);
    return (sel == 1) ? 1 : 2;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 1) ? bus1.ready_out : bus2.ready_out;
  endfunction

  function automatic logic get_stall(input int sel);
    return (sel == 1) ? bus1.stall_out : bus2.stall_out;
  endfunction

  function automatic logic get_error(input int sel);
    return (sel == 1) ? bus1.error_out : bus2.error_out;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 1) ? bus1.rdata_out : bus2.rdata_out;
  endfunction

  task automatic drive(input int sel, input logic re, input logic we, input logic [1:0] size,
                       input logic [9:0] addr, input logic [31:0] wdata);
    if (sel == 1) begin
      bus1.data_mem_re_in = re; bus1.data_mem_we_in = we; bus1.data_mem_size_in = size;
      bus1.addr_in = addr; bus1.wdata_in = wdata;
    end else begin
      bus2.data_mem_re_in = re; bus2.data_mem_we_in = we; bus2.data_mem_size_in = size;
      bus2.addr_in = addr; bus2.wdata_in = wdata;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference behaviour: legality rules, byte-level store, sign-extending load.
  task automatic model_access(input int sel, input logic re, input logic we, input logic [1:0] size,
                              input logic [9:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_rdata, output logic exp_err);
    int     nbytes;
    longint v;
    exp_err = (re && we) || (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0);
    exp_rdata = 32'd0;
    if (exp_err) return;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (we) begin
      for (int i = 0; i < nbytes; i++) model_mem[sel][int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v + (longint'(model_mem[sel][int'(addr) + i]) << (8 * i));
      if (v >= (longint'(1) << (8 * nbytes - 1))) v = v - (longint'(1) << (8 * nbytes));
      exp_rdata = v[31:0];
    end
  endtask

  // Issue one request in the cycle after the previous completion and wait for ready.
  task automatic apply_stimulus(input int sel, input logic re, input logic we, input logic [1:0] size,
                                input logic [9:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err, output int lat,
                                output int stalls, output logic stall_done, output int rdy_cyc);
    @(negedge clk_in);
    drive(sel, re, we, size, addr, wdata);
    #1;
    lat = 0;
    stalls = 0;
    while (!get_ready(sel) && lat < 40) begin
      if (get_stall(sel)) stalls++;
      @(negedge clk_in);
      #1;
      lat++;
    end
    rdata      = get_rdata(sel);
    err        = get_error(sel);
    stall_done = get_stall(sel);
    rdy_cyc    = cyc;
    drive(sel, 1'b0, 1'b0, 2'd0, 10'd0, 32'd0);
    if (lat >= 40) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL timeout: no ready after %0d cycles, expected %0d", lat, lat_of(sel) + 1);
    end
  endtask

  // Full access with every observable compared against the reference model.
  task automatic checked_access(input int sel, input string tag, input logic re, input logic we,
                                input logic [1:0] size, input logic [9:0] addr, input logic [31:0] wdata,
                                output logic [31:0] exp_rdata, output int rdy_cyc);
    logic [31:0] rdata;
    logic        err, exp_err, stall_done;
    int          lat, stalls;
    model_access(sel, re, we, size, addr, wdata, exp_rdata, exp_err);
    apply_stimulus(sel, re, we, size, addr, wdata, rdata, err, lat, stalls, stall_done, rdy_cyc);
    check_output({tag, " rdata"}, rdata, exp_rdata);
    check_output({tag, " error"}, {31'd0, err}, {31'd0, exp_err});
    check_output({tag, " latency"}, lat, lat_of(sel) + 1);
    check_output({tag, " stall cycles"}, stalls, lat_of(sel) + 1);
    check_output({tag, " stall in done"}, {31'd0, stall_done}, 32'd0);
  endtask

  initial begin
    logic [31:0] rdata, exp_rdata;
    logic        err, exp_err, stall_done, re, we;
    logic [1:0]  size;
    logic [9:0]  addr;
    int          lat, stalls, rdy_cyc, prev_cyc, r;

    vecs[0]  = '{1'b0, 1'b1, 2'd2, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 10'h010, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 10'h020, 32'h11223344, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 10'h023, 32'h000000AA, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 10'h020, 32'h00000000, 32'hAA223344, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 10'h030, 32'h00008080, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 10'h030, 32'h00000000, 32'hFFFFFF80, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 10'h030, 32'h00000000, 32'hFFFF8080, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 10'h031, 32'h00000000, 32'hFFFFFF80, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 10'h032, 32'h00000000, 32'h00000000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 10'h040, 32'h12345678, 32'h00000000, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 10'h041, 32'h0000BEEF, 32'h00000000, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 10'h040, 32'h00000000, 32'h12345678, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'd3, 10'h040, 32'h00000000, 32'h00000000, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 2'd2, 10'h040, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 2'd2, 10'h040, 32'h00000000, 32'h12345678, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 2'd1, 10'h022, 32'h00000000, 32'hFFFFAA22, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 2'd2, 10'h042, 32'h00000000, 32'h00000000, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 2'd1, 10'h032, 32'h00007FFF, 32'h00000000, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 2'd2, 10'h030, 32'h00000000, 32'h7FFF8080, 1'b0};

    drive(0, 1'b0, 1'b0, 2'd0, 10'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 10'd0, 32'd0);
    repeat (3) @(negedge clk_in);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_output($sformatf("reset%0d rdata", s), get_rdata(s), 32'd0);
      check_output($sformatf("reset%0d ready", s), {31'd0, get_ready(s)}, 32'd0);
      check_output($sformatf("reset%0d error", s), {31'd0, get_error(s)}, 32'd0);
      check_output($sformatf("reset%0d stall", s), {31'd0, get_stall(s)}, 32'd0);
    end
    rst_n_in = 1'b1;

    $display("[TB] clearing LATENCY=2 memory");
    for (int w = 0; w < 256; w++) begin
      apply_stimulus(0, 1'b0, 1'b1, 2'd2, 10'(w * 4), 32'd0, rdata, err, lat, stalls, stall_done, rdy_cyc);
    end
    for (int b = 0; b < 1024; b++) model_mem[0][b] = 8'h00;

    $display("[TB] vector table");
    prev_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      model_access(0, vecs[i].re, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, exp_rdata, exp_err);
      apply_stimulus(0, vecs[i].re, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                     rdata, err, lat, stalls, stall_done, rdy_cyc);
      check_output($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      check_output($sformatf("vec%0d error", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check_output($sformatf("vec%0d latency", i), lat, 3);
      check_output($sformatf("vec%0d stall cycles", i), stalls, 3);
      if (prev_cyc >= 0) check_output($sformatf("vec%0d period", i), rdy_cyc - prev_cyc, 4);
      prev_cyc = rdy_cyc;
    end

    $display("[TB] reset during store wait");
    @(negedge clk_in);
    drive(0, 1'b0, 1'b1, 2'd2, 10'h050, 32'hCAFEF00D);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 10'd0, 32'd0);
    @(negedge clk_in);
    #1;
    check_output("rst mid stall", {31'd0, bus2.stall_out}, 32'd0);
    check_output("rst mid ready", {31'd0, bus2.ready_out}, 32'd0);
    check_output("rst mid rdata", bus2.rdata_out, 32'd0);
    @(negedge clk_in);
    #1;
    check_output("rst after ready", {31'd0, bus2.ready_out}, 32'd0);
    rst_n_in = 1'b1;
    checked_access(0, "lw after rst", 1'b1, 1'b0, 2'd2, 10'h050, 32'd0, exp_rdata, rdy_cyc);
    check_output("lw after rst value", exp_rdata, 32'h00000000);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 15);
      re = (r < 7) || (r == 14);
      we = (r >= 7);
      r  = $urandom_range(0, 9);
      size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      addr = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      checked_access(0, $sformatf("rand%0d", n), re, we, size, addr, $urandom, exp_rdata, rdy_cyc);
    end

    $display("[TB] LATENCY=1 back-to-back");
    checked_access(1, "l1 sw", 1'b0, 1'b1, 2'd2, 10'h010, 32'hA55A0FF0, exp_rdata, prev_cyc);
    checked_access(1, "l1 lw", 1'b1, 1'b0, 2'd2, 10'h010, 32'd0, exp_rdata, rdy_cyc);
    check_output("l1 lw value", exp_rdata, 32'hA55A0FF0);
    check_output("l1 period sw-lw", rdy_cyc - prev_cyc, 3);
    prev_cyc = rdy_cyc;
    checked_access(1, "l1 sb", 1'b0, 1'b1, 2'd0, 10'h011, 32'h00000080, exp_rdata, rdy_cyc);
    check_output("l1 period lw-sb", rdy_cyc - prev_cyc, 3);
    checked_access(1, "l1 lb", 1'b1, 1'b0, 2'd0, 10'h011, 32'd0, exp_rdata, rdy_cyc);
    check_output("l1 lb value", exp_rdata, 32'hFFFFFF80);
    checked_access(1, "l1 lh", 1'b1, 1'b0, 2'd1, 10'h010, 32'd0, exp_rdata, rdy_cyc);
    check_output("l1 lh value", exp_rdata, 32'hFFFF80F0);
    checked_access(1, "l1 bad sh", 1'b0, 1'b1, 2'd1, 10'h013, 32'h00001234, exp_rdata, rdy_cyc);
    checked_access(1, "l1 lw again", 1'b1, 1'b0, 2'd2, 10'h010, 32'd0, exp_rdata, rdy_cyc);
    check_output("l1 lw again value", exp_rdata, 32'hA55A80F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the single-cycle MIPS datapath. It consumes the load/store requests the control unit raises (`data_mem_re`, `data_mem_we`, `data_mem_size`) together with the ALU-computed byte address and the store data. It performs byte, halfword and word accesses on an internal word-organised RAM with a fixed, parameterised latency. While an access is in flight it stalls the datapath; the stall signal gates the PC enable.

## Interface

Parameters
- `ADDR_WIDTH`, 10: byte-address width; RAM holds 2^(ADDR_WIDTH-2) 32-bit words.
- `LATENCY`, 2: wait cycles per access, legal range 1..15.

Ports
- `clk_in`  input  1  clock; all state changes on rising edge.
- `rst_n_in`  input  1  reset, synchronous, active-low.
- `data_mem_re_in`  input  1  load request.
- `data_mem_we_in`  input  1  store request.
- `data_mem_size_in`  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- `addr_in`  input  ADDR_WIDTH  byte address, little-endian.
- `wdata_in`  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata_out`  output  32  load result, sign-extended for byte and half.
- `stall_out`  output  1  datapath must hold PC and request stable.
- `ready_out`  output  1  one-cycle completion pulse.
- `error_out`  output  1  one-cycle pulse with `ready_out` on an illegal access.

## Operation

- The FSM has three states: IDLE, WAIT and DONE. A 4-bit wait counter runs in WAIT.
- **IDLE**
  - If `re` or `we` is high: latch the request (addr, size, wdata, re, we), set counter=0, go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - Increment the counter each cycle.
  - When counter==LATENCY-1, perform the access at that clock edge and go to DONE.
- **DONE**
  - Drive `ready_out`=1 for one cycle, then return to IDLE.
  - Requests are not sampled in DONE, because the datapath advances at this edge.
- **Word index:** addr[ADDR_WIDTH-1:2]. **Lane:** addr[1:0]. Lane 0 is bits [7:0].
- **Store**
  - Read-modify-write of the addressed word. Only the selected lanes change:
    - byte: lane addr[1:0] <- wdata[7:0]
    - half: lanes {addr[1],0} and {addr[1],1} <- wdata[15:0]
    - word: whole word <- wdata
  - `rdata_out`=0 at completion.
- **Load:** extract the lanes, sign-extend bit 7 (byte) or bit 15 (half) to 32 bits, and register the result into `rdata_out` on entry to DONE.
- **Illegal access** is any of: re&we both high; size==11; half with addr[0]=1; word with addr[1:0]!=0.
  - Full latency still elapses.
  - No RAM write occurs.
  - `rdata_out`=0.
  - `error_out`=1 in DONE.
- `rdata_out` holds its value until the next completion. `error_out` and `ready_out` are low outside DONE.
- RAM contents are not affected by reset and have no defined initial value.

## Timing

- **Reset** (rst_n_in low at an edge):
  - state=IDLE, counter=0, rdata_out=0, ready_out=0, error_out=0.
  - Any in-flight access is aborted. A store that has not reached its commit edge does not write.
  - Reset takes priority over every other event.
- **stall_out**
  - Combinational: 1 in IDLE when re|we is high; 1 in WAIT; 0 in DONE and in idle with no request.
  - Thus a request is stalled for exactly LATENCY+1 cycles, counting the IDLE acceptance cycle plus LATENCY WAIT cycles.
- **Latency:** request seen in IDLE at cycle T; RAM commit / rdata register at the edge ending cycle T+LATENCY; ready_out high during cycle T+LATENCY+1.
- **Back-to-back:** a new request present in the cycle after DONE is accepted immediately. The minimum period is LATENCY+2 cycles per access.
- **Request stability:** input changes after acceptance are ignored because the request is latched. The datapath holds the inputs stable while stalled regardless.

## Test plan

- **Word store then load, LATENCY=2.**
  - sw 0xDEADBEEF @0x010, then lw @0x010.
  - Required: ready pulses at T+3 for each access, stall high 3 cycles each, rdata_out=0xDEADBEEF.
- **Byte merge.**
  - sw 0x11223344 @0x020; sb 0xAA @0x023; lw @0x020.
  - Required: rdata_out=0xAA223344.
- **Sign extension.**
  - sw 0x00008080 @0x030; lb @0x030 -> rdata_out=0xFFFFFF80.
  - lh @0x030 -> 0xFFFF8080.
  - lb @0x031 -> 0xFFFFFF80.
  - lb @0x032 -> 0x00000000.
- **Illegal accesses.**
  - sh 0xBEEF @0x041 after sw 0x12345678 @0x040: error_out=1 with ready, following lw @0x040 returns 0x12345678.
  - size=11 load -> error_out=1, rdata_out=0.
  - re&we both high -> error_out=1, no write.
- **Reset mid-store.** Start sw 0xCAFEF00D @0x050 (prior contents 0x0), assert rst_n_in low during the first WAIT cycle.
  - Required: next cycle is IDLE, stall_out=0, ready_out=0, rdata_out=0.
  - A subsequent lw @0x050 returns 0x00000000.
- **Back-to-back and LATENCY=1 build.**
  - lw immediately following sw with no gap.
  - Required: second acceptance occurs the cycle after DONE, and the period is LATENCY+2 cycles.
